ls_store_buf: RTL and testbench
===============================

LS_STORE_BUF -- requirements
Module: ls_store_buf

Interface
REQ-001 Parameter XLEN, default 64, data and address width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, number of buffer entries; power of two, 2..16.
REQ-003 Parameter NB = XLEN/8, derived; bytes per memory word; not overridable.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 st_valid  in  1  store request from the load/store stage.
REQ-007 st_ready  out  1  buffer can accept a store this cycle.
REQ-008 st_addr  in  XLEN  byte address of the store.
REQ-009 st_data  in  XLEN  store data, right-justified (bits [8<<st_size)-1:0] used).
REQ-010 st_size  in  2  0=byte, 1=half, 2=word, 3=dword; 3 is illegal when XLEN=32.
REQ-011 st_misalign  out  1  one-cycle pulse: the offered store was misaligned and dropped.
REQ-012 ld_addr, ld_size  in  XLEN, 2  combinational forwarding lookup for the current load.
REQ-013 ld_valid  in  1  lookup qualifier.
REQ-014 fwd_data  out  XLEN  merged buffered bytes at the load's aligned word.
REQ-015 fwd_mask  out  NB  bytes of fwd_data that are valid.
REQ-016 fwd_hit  out  1  every byte the load needs is covered by fwd_mask.
REQ-017 ld_stall  out  1  the load overlaps buffered bytes but is not fully covered.
REQ-018 mem_wvalid, mem_wready  out, in  1, 1  memory write handshake.
REQ-019 mem_waddr, mem_wdata, mem_wmask  out  XLEN, XLEN, NB  aligned address, lane-placed data, byte strobes.
REQ-020 empty  out  1  no valid entries; used for fence and trap drain.

Function
REQ-021 The buffer SHALL be a circular FIFO of DEPTH entries {valid, word address = addr & ~(NB-1), lane data, NB-bit mask}, with head/tail pointers and a count of width log2(DEPTH)+1.
REQ-022 st_ready = (count != DEPTH); there is no push-through when full, even if a pop occurs in the same cycle.
REQ-023 On st_valid & st_ready & aligned, the entry SHALL be written at tail with data shifted to byte lane addr[log2(NB)-1:0] and mask = ((1<<(1<<st_size))-1) shifted by that lane.
REQ-024 A store is aligned iff addr mod (1<<st_size) == 0; a misaligned store SHALL NOT be enqueued, SHALL raise st_misalign for exactly one cycle, and is consumed (no retry).
REQ-025 mem_wvalid = !empty; mem_waddr/wdata/wmask SHALL equal the head entry and remain stable while mem_wvalid & !mem_wready.
REQ-026 On mem_wvalid & mem_wready, the head SHALL be popped at that edge; a simultaneous push and pop leaves count unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 Forwarding SHALL be combinational: over valid entries whose word address equals ld_addr's word address, bytes merge oldest to youngest, the youngest writer winning per byte; fwd_mask is the OR of their masks.
REQ-029 Needed bytes = load mask computed as in REQ-023; fwd_hit = ld_valid & (needed & ~fwd_mask)==0 & (needed & fwd_mask)!=0.
REQ-030 ld_stall = ld_valid & (needed & fwd_mask)!=0 & !fwd_hit; with no overlap, both are 0 and fwd_mask may be nonzero.
REQ-031 A store accepted in cycle N SHALL be visible to forwarding from cycle N+1; same-cycle store/load bypass is not provided.
REQ-032 Fully-hit forwarding SHALL work when the matching entry is the head being popped in the same cycle.

Reset
REQ-033 While rst_n=0: count=0, head=tail=0, all valid bits 0, st_misalign=0, mem_wvalid=0, fwd_hit=0, ld_stall=0, empty=1, st_ready=1; entry data is don't-care.
REQ-034 Reset asserted mid-handshake SHALL drop mem_wvalid immediately and discard all pending stores.

Verification
REQ-035 XLEN=64: sw 0xDEADBEEF @0x1004, mem_wready=1 -> next cycle mem_waddr=0x1000, wmask=0xF0, wdata[63:32]=0xDEADBEEF.
REQ-036 DEPTH=4, mem_wready=0, five stores -> st_ready=0 after the fourth; the fifth is held; wready=1 for one cycle -> count 3, then the fifth is accepted.
REQ-037 sd 0x1122334455667788 @0x2000, then sb 0xAA @0x2003, then ld @0x2000 size 3 -> fwd_hit=1, fwd_data=0x11223344AA667788.
REQ-038 sh 0xBEEF @0x3000, then lw @0x3000 -> ld_stall=1, fwd_hit=0; drain the entry -> ld_stall=0, fwd_mask=0.
REQ-039 sw @0x4002 -> st_misalign pulse, count unchanged, mem_wvalid stays 0.
REQ-040 Three queued stores, mem_wready=0, rst_n low mid-cycle -> empty=1, mem_wvalid=0 immediately; after release no writes are issued.

Source files
------------

// File: rtl/ls_store_buf.sv
// Store buffer between the load/store stage and memory: an in-order FIFO of
// aligned word writes, with byte-granular forwarding to loads.
module ls_store_buf #(
   parameter  int XLEN  = 64,
   parameter  int DEPTH = 4,
   localparam int NB    = XLEN / 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            st_valid,
   output logic            st_ready,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   input  logic [1:0]      st_size,
   output logic            st_misalign,
   input  logic            ld_valid,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [1:0]      ld_size,
   output logic [XLEN-1:0] fwd_data,
   output logic [NB-1:0]   fwd_mask,
   output logic            fwd_hit,
   output logic            ld_stall,
   output logic            mem_wvalid,
   input  logic            mem_wready,
   output logic [XLEN-1:0] mem_waddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [NB-1:0]   mem_wmask,
   output logic            empty
);
   localparam int LB = $clog2(NB);
   localparam int LD = $clog2(DEPTH);
   localparam logic [XLEN-1:0] WMASK = ~XLEN'(NB - 1);

   function automatic logic [NB-1:0] byte_mask(input logic [LB-1:0] lane, input logic [1:0] size);
      logic [NB-1:0] m;
      int n;
      n = 1 << size;
      m = '0;
      for (int i = 0; i < NB; i++) m[i] = (i >= int'(lane)) && (i < int'(lane) + n);
      return m;
   endfunction

   // A dword store on a 32-bit machine has no legal encoding; drop it like a misaligned one.
   function automatic logic is_aligned(input logic [2:0] lo, input logic [1:0] size);
      return ((int'(lo) & ((1 << size) - 1)) == 0) && !(XLEN == 32 && size == 2'd3);
   endfunction

   logic [DEPTH-1:0] vld_q;
   logic [XLEN-1:0]  waddr_q [DEPTH];
   logic [XLEN-1:0]  data_q  [DEPTH];
   logic [NB-1:0]    mask_q  [DEPTH];
   logic [LD-1:0]    head_q, tail_q;
   logic [LD:0]      count_q;
   logic             misalign_q;

   logic [NB-1:0]    st_mask, ld_need;
   logic [XLEN-1:0]  st_shift, st_lanes;
   logic             st_ok, push, pop;

   assign st_ok    = is_aligned(st_addr[2:0], st_size);
   assign st_mask  = byte_mask(st_addr[LB-1:0], st_size);
   assign st_shift = st_data << {st_addr[LB-1:0], 3'b000};

   always_comb begin
      st_lanes = '0;
      for (int b = 0; b < NB; b++)
         if (st_mask[b]) st_lanes[8*b +: 8] = st_shift[8*b +: 8];
   end

   assign st_ready    = (count_q != DEPTH[LD:0]);
   assign empty       = (count_q == '0);
   assign mem_wvalid  = !empty;
   assign mem_waddr   = waddr_q[head_q];
   assign mem_wdata   = data_q[head_q];
   assign mem_wmask   = mask_q[head_q];
   assign st_misalign = misalign_q;
   assign push        = st_valid && st_ready && st_ok;
   assign pop         = mem_wvalid && mem_wready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q      <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= st_valid && st_ready && !st_ok;
         // Push needs a free slot and pop needs an entry, so they never hit the same index.
         if (push) begin
            vld_q[tail_q] <= 1'b1;
            tail_q        <= tail_q + 1'b1;
         end
         if (pop) begin
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + 1'b1;
         end
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Entry payload is qualified by vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         waddr_q[tail_q] <= st_addr & WMASK;
         data_q[tail_q]  <= st_lanes;
         mask_q[tail_q]  <= st_mask;
      end
   end

   // Walk oldest to youngest so the youngest writer of each byte wins.
   always_comb begin
      logic [LD-1:0] idx;
      idx      = '0;
      fwd_data = '0;
      fwd_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + LD'(k);
         if (vld_q[idx] && waddr_q[idx] == (ld_addr & WMASK)) begin
            for (int b = 0; b < NB; b++)
               if (mask_q[idx][b]) fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
            fwd_mask = fwd_mask | mask_q[idx];
         end
      end
   end

   assign ld_need  = byte_mask(ld_addr[LB-1:0], ld_size);
   assign fwd_hit  = ld_valid && ((ld_need & ~fwd_mask) == '0) && ((ld_need & fwd_mask) != '0);
   assign ld_stall = ld_valid && ((ld_need & fwd_mask) != '0) && !fwd_hit;

endmodule

// File: tb/tb_ls_store_buf.sv
// Directed bench for ls_store_buf (XLEN=64, DEPTH=4): memory writes are
// checked against a scoreboard queue filled as stores are accepted.
module tb_ls_store_buf;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        st_valid = 1'b0, st_ready, st_misalign;
   logic [63:0] st_addr = '0, st_data = '0;
   logic [1:0]  st_size = '0;
   logic        ld_valid = 1'b0;
   logic [63:0] ld_addr = '0;
   logic [1:0]  ld_size = '0;
   logic [63:0] fwd_data;
   logic [7:0]  fwd_mask;
   logic        fwd_hit, ld_stall;
   logic        mem_wvalid, mem_wready = 1'b0;
   logic [63:0] mem_waddr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        empty;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } wr_t;

   wr_t q[$];
   int  tests = 0, fails = 0;
   logic st_acc;

   ls_store_buf #(.XLEN(64), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_size(st_size), .st_misalign(st_misalign),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
      .fwd_data(fwd_data), .fwd_mask(fwd_mask), .fwd_hit(fwd_hit), .ld_stall(ld_stall),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic wr_t expect_wr(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
      wr_t w;
      logic [127:0] t;
      int lane;
      lane   = int'(a[2:0]);
      t      = ({64'd0, d} & ((128'd1 << (8 << sz)) - 128'd1)) << (8 * lane);
      w.addr = a & ~64'h7;
      w.data = t[63:0];
      w.mask = 8'((((1 << (1 << sz)) - 1) << lane) & 'hFF);
      return w;
   endfunction

   // Handshake is decided by the inputs held through the next rising edge.
   always @(negedge clk) begin
      if (rst_n && mem_wvalid && mem_wready) begin
         wr_t e;
         chk("wr_pending", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("wr_addr", mem_waddr, e.addr);
            chk("wr_data", mem_wdata, e.data);
            chk("wr_mask", 64'(mem_wmask), 64'(e.mask));
         end
      end
   end

   task automatic st_begin(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
      st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
   endtask

   task automatic st_end();
      st_acc = st_ready;
      @(posedge clk); #1;
      st_valid = 1'b0;
      if (st_acc && (st_addr % (64'd1 << st_size)) == 0) q.push_back(expect_wr(st_addr, st_data, st_size));
   endtask

   task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
      st_begin(a, d, sz);
      st_end();
   endtask

   task automatic drain();
      int n = 0;
      mem_wready = 1'b1;
      while (!empty && n < 20) begin @(posedge clk); #1; n++; end
      chk("drain_empty", 64'(empty), 64'd1);
      mem_wready = 1'b0;
   endtask

   initial begin
      #3;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_ready", 64'(st_ready), 64'd1);
      chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
      chk("rst_hit", 64'(fwd_hit), 64'd0);
      chk("rst_stall", 64'(ld_stall), 64'd0);
      chk("rst_misalign", 64'(st_misalign), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // sw to upper half of a dword
      mem_wready = 1'b1;
      store(64'h1004, 64'hDEAD_BEEF, 2'd2);
      chk("sw_wvalid", 64'(mem_wvalid), 64'd1);
      chk("sw_waddr", mem_waddr, 64'h1000);
      chk("sw_wmask", 64'(mem_wmask), 64'hF0);
      chk("sw_wdata_hi", 64'(mem_wdata[63:32]), 64'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("sw_drained", 64'(empty), 64'd1);

      // fill, back-pressure, no push-through on pop
      mem_wready = 1'b0;
      for (int i = 0; i < 4; i++) store(64'h6000 + 64'(8 * i), 64'h0101_0101_0000_0000 * 64'(i + 1) + 64'(i), 2'd3);
      chk("full_ready", 64'(st_ready), 64'd0);
      st_begin(64'h6020, 64'hCAFE_F00D_1234_5678, 2'd3);
      @(posedge clk); #1;
      chk("full_hold", 64'(st_ready), 64'd0);
      mem_wready = 1'b1;
      chk("full_nopush", 64'(st_ready), 64'd0);
      @(posedge clk); #1;
      mem_wready = 1'b0;
      chk("after_pop_ready", 64'(st_ready), 64'd1);
      st_end();
      chk("refull_ready", 64'(st_ready), 64'd0);
      drain();

      // youngest byte wins; hit holds while head is popping
      store(64'h2000, 64'h1122_3344_5566_7788, 2'd3);
      store(64'h2003, 64'hFFFF_FFAA, 2'd0);
      ld_valid = 1'b1; ld_addr = 64'h2000; ld_size = 2'd3; #1;
      chk("merge_hit", 64'(fwd_hit), 64'd1);
      chk("merge_data", fwd_data, 64'h1122_3344_AA66_7788);
      chk("merge_mask", 64'(fwd_mask), 64'hFF);
      chk("merge_stall", 64'(ld_stall), 64'd0);
      mem_wready = 1'b1; #1;
      chk("pop_hit", 64'(fwd_hit), 64'd1);
      chk("pop_data", fwd_data, 64'h1122_3344_AA66_7788);
      @(posedge clk); #1;
      mem_wready = 1'b0;
      chk("partial_stall", 64'(ld_stall), 64'd1);
      chk("partial_hit", 64'(fwd_hit), 64'd0);
      chk("partial_mask", 64'(fwd_mask), 64'h08);
      drain();

      // partial cover stalls; same-cycle store is not bypassed
      ld_addr = 64'h3000; ld_size = 2'd2;
      st_begin(64'h3000, 64'hBEEF, 2'd1); #1;
      chk("no_bypass", 64'(fwd_mask), 64'h00);
      st_end();
      chk("sh_stall", 64'(ld_stall), 64'd1);
      chk("sh_hit", 64'(fwd_hit), 64'd0);
      chk("sh_mask", 64'(fwd_mask), 64'h03);
      drain();
      chk("sh_stall_gone", 64'(ld_stall), 64'd0);
      chk("sh_mask_gone", 64'(fwd_mask), 64'h00);

      // same word, disjoint bytes: neither hit nor stall
      store(64'h5000, 64'hAA, 2'd0);
      ld_addr = 64'h5001; ld_size = 2'd0; #1;
      chk("disj_mask", 64'(fwd_mask), 64'h01);
      chk("disj_hit", 64'(fwd_hit), 64'd0);
      chk("disj_stall", 64'(ld_stall), 64'd0);
      ld_addr = 64'h5000; #1;
      chk("lb_hit", 64'(fwd_hit), 64'd1);
      chk("lb_data", 64'(fwd_data[7:0]), 64'hAA);
      drain();
      ld_valid = 1'b0;

      // misaligned store is dropped with a single pulse
      store(64'h4002, 64'h1234_5678, 2'd2);
      chk("mis_pulse", 64'(st_misalign), 64'd1);
      chk("mis_empty", 64'(empty), 64'd1);
      chk("mis_wvalid", 64'(mem_wvalid), 64'd0);
      @(posedge clk); #1;
      chk("mis_pulse_end", 64'(st_misalign), 64'd0);
      chk("mis_still_empty", 64'(empty), 64'd1);

      // reset mid-cycle discards queued stores
      for (int i = 0; i < 3; i++) store(64'h7000 + 64'(8 * i), 64'(i + 5), 2'd3);
      chk("pre_rst_wvalid", 64'(mem_wvalid), 64'd1);
      #2 rst_n = 1'b0; #1;
      chk("arst_empty", 64'(empty), 64'd1);
      chk("arst_wvalid", 64'(mem_wvalid), 64'd0);
      chk("arst_ready", 64'(st_ready), 64'd1);
      q.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      mem_wready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("post_rst_wvalid", 64'(mem_wvalid), 64'd0);
      end
      mem_wready = 1'b0;
      chk("sb_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
